// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle between a master and the axil_reg_slave register file.
// Holds the five channels (AW, W, B, AR, R); clock and reset stay outside.
interface axil_reg_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  // Write address channel
  logic                  AWVALID;
  logic                  AWREADY;
  logic [ADDR_WIDTH-1:0] AWADDR;

  // Write data channel
  logic                  WVALID;
  logic                  WREADY;
  logic [DATA_WIDTH-1:0] WDATA;

  // Write response channel
  logic                  BVALID;
  logic                  BREADY;
  logic [1:0]            BRESP;

  // Read address channel
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;

  // Read data channel
  logic                  RVALID;
  logic                  RREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;

  // Bus master view: drives requests and response-ready
  modport master (
    output AWVALID, AWADDR, WVALID, WDATA, BREADY, ARVALID, ARADDR, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  // Register-file view: accepts requests and drives responses
  modport slave (
    input  AWVALID, AWADDR, WVALID, WDATA, BREADY, ARVALID, ARADDR, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave register file.
// NUM_REGS word registers; register 0 is a read-only ID constant. Word-aligned
// decode (low two address bits ignored), OKAY/SLVERR/DECERR responses, and the
// full register contents driven out flat on regs_o for SoC control fan-out.
// AW and W each have a one-entry holding register so either may arrive first;
// a write commits once both are held and no write response is outstanding.
// Every bus output comes straight from a flop: no combinational in-to-out path.
module axil_reg_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA5A5_0001
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  axil_reg_slave_if.slave                bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int         IDX_W       = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Write holding registers
  logic                  aw_full_q, aw_full_d;
  logic [IDX_W-1:0]      aw_idx_q,  aw_idx_d;
  logic                  w_full_q,  w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;

  // Write response
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q,  bresp_d;

  // Read response
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q,  rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;

  // Writable registers; slot 0 is the ID constant and has no storage
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

  // Handshake and commit qualifiers
  logic             aw_hs;
  logic             w_hs;
  logic             ar_hs;
  logic             commit;
  logic [IDX_W-1:0] ar_idx;

  // Byte-lane bits of both addresses carry no meaning in a word register file
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.AWADDR[1:0], bus.ARADDR[1:0]};

  assign aw_hs  = bus.AWVALID & ~aw_full_q;
  assign w_hs   = bus.WVALID  & ~w_full_q;
  assign ar_hs  = bus.ARVALID & ~rvalid_q;
  assign commit = aw_full_q & w_full_q & ~bvalid_q;
  assign ar_idx = bus.ARADDR[ADDR_WIDTH-1:2];

  assign bus.AWREADY = ~aw_full_q;
  assign bus.WREADY  = ~w_full_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BRESP   = bresp_q;
  assign bus.ARREADY = ~rvalid_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;

  // Capture AW and W independently; a commit frees both holding slots at once
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = bus.AWADDR[ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = bus.WDATA;
    end
  end

  // Commit the held write into the register array and raise the B response
  always_comb begin
    regs_d   = regs_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (commit) begin
      bvalid_d = 1'b1;
      if (aw_idx_q >= IDX_W'(NUM_REGS)) begin
        bresp_d = RESP_DECERR;
      end else if (aw_idx_q == '0) begin
        bresp_d = RESP_SLVERR;
      end else begin
        bresp_d = RESP_OKAY;
        for (int i = 1; i < NUM_REGS; i++) begin
          if (aw_idx_q == IDX_W'(i)) begin
            regs_d[i] = w_data_q;
          end
        end
      end
    end else if (bvalid_q && bus.BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  // Load read data from the current (pre-commit) register values on AR accept
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (ar_idx >= IDX_W'(NUM_REGS)) begin
        rdata_d = '0;
        rresp_d = RESP_DECERR;
      end else begin
        rresp_d = RESP_OKAY;
        rdata_d = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
          if (ar_idx == IDX_W'(i)) begin
            rdata_d = regs_q[i];
          end
        end
      end
    end else if (rvalid_q && bus.RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers; reset discards any held or pending transaction
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
    end
  end

  // Flatten the register file for control fan-out, ID constant in slot 0
  always_comb begin
    regs_o                 = '0;
    regs_o[DATA_WIDTH-1:0] = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Testbench for axil_reg_slave: directed scenarios followed by random
// transactions, checked against a register-array reference model.
module tb_axil_reg_slave;

  localparam int          NREG = 8;
  localparam logic [31:0] ID   = 32'hA5A5_0001;

  logic ACLK;
  logic ARESETN;
  logic [NREG*32-1:0] regs_o;

  axil_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_reg_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS  (NREG),
    .ID_VALUE  (ID)
  ) dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .bus    (bus),
    .regs_o (regs_o)
  );

  // Free-running clock
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Global watchdog so the run can never hang
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  int total = 0;
  int bad   = 0;

  // Reference model: plain array of register values, slot 0 unused
  logic [31:0] m_regs [NREG];

  function automatic logic [1:0] exp_wr_resp(input logic [31:0] addr);
    int idx;
    idx = int'(addr >> 2);
    if (idx >= NREG) return 2'b11;
    if (idx == 0)    return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [33:0] exp_read(input logic [31:0] addr);
    int idx;
    idx = int'(addr >> 2);
    if (idx >= NREG) return {2'b11, 32'h0};
    if (idx == 0)    return {2'b00, ID};
    return {2'b00, m_regs[idx]};
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkRegs();
    for (int i = 0; i < NREG; i++) begin
      checkOutput($sformatf("regs_o[%0d]", i), {32'h0, regs_o[i*32 +: 32]},
                  {32'h0, (i == 0) ? ID : m_regs[i]});
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
  endtask

  task automatic idle_inputs();
    bus.AWVALID = 1'b0; bus.AWADDR = '0;
    bus.WVALID  = 1'b0; bus.WDATA  = '0;
    bus.BREADY  = 1'b0;
    bus.ARVALID = 1'b0; bus.ARADDR = '0;
    bus.RREADY  = 1'b0;
  endtask

  task automatic doReset(input int cycles);
    idle_inputs();
    ARESETN = 1'b0;
    repeat (cycles) tick();
    ARESETN = 1'b1;
    model_reset();
  endtask

  // Full write: AW/W offered after independent delays, B accepted after b_dly
  task automatic applyWrite(input logic [31:0] addr, input logic [31:0] data,
                            input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done, w_done, aw_hs, w_hs;
    int c;
    logic [1:0] resp;
    aw_done = 0; w_done = 0; c = 0;
    bus.AWADDR = addr;
    bus.WDATA  = data;
    while (!(aw_done && w_done) && c < 40) begin
      if (!aw_done) bus.AWVALID = (c >= aw_dly);
      if (!w_done)  bus.WVALID  = (c >= w_dly);
      if (w_done && !aw_done) checkOutput("wready_held", {63'h0, bus.WREADY}, 64'h0);
      if (aw_done && !w_done) checkOutput("awready_held", {63'h0, bus.AWREADY}, 64'h0);
      aw_hs = bus.AWVALID && bus.AWREADY;
      w_hs  = bus.WVALID && bus.WREADY;
      tick();
      if (aw_hs) begin aw_done = 1; bus.AWVALID = 1'b0; end
      if (w_hs)  begin w_done  = 1; bus.WVALID  = 1'b0; end
      c++;
    end
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    checkOutput("wr_handshakes", {62'h0, aw_done, w_done}, 64'h3);
    checkOutput("bvalid_not_early", {63'h0, bus.BVALID}, 64'h0);
    tick();
    resp = exp_wr_resp(addr);
    if (resp == 2'b00) m_regs[int'(addr >> 2)] = data;
    checkOutput("bvalid_latency", {63'h0, bus.BVALID}, 64'h1);
    checkOutput("bresp", {62'h0, bus.BRESP}, {62'h0, resp});
    for (int k = 0; k < b_dly; k++) begin
      tick();
      checkOutput("bvalid_hold", {63'h0, bus.BVALID}, 64'h1);
      checkOutput("bresp_hold", {62'h0, bus.BRESP}, {62'h0, resp});
    end
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    checkOutput("bvalid_clear", {63'h0, bus.BVALID}, 64'h0);
    checkRegs();
  endtask

  // Full read: AR accepted, R checked at latency 1, held r_dly cycles, accepted
  task automatic applyRead(input logic [31:0] addr, input int r_dly);
    int c;
    logic [33:0] exp;
    c = 0;
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    while (!bus.ARREADY && c < 20) begin
      tick();
      c++;
    end
    checkOutput("arready", {63'h0, bus.ARREADY}, 64'h1);
    exp = exp_read(addr);
    tick();
    bus.ARVALID = 1'b0;
    checkOutput("rvalid_latency", {63'h0, bus.RVALID}, 64'h1);
    checkOutput("rdata", {32'h0, bus.RDATA}, {32'h0, exp[31:0]});
    checkOutput("rresp", {62'h0, bus.RRESP}, {62'h0, exp[33:32]});
    for (int k = 0; k < r_dly; k++) begin
      tick();
      checkOutput("rvalid_hold", {63'h0, bus.RVALID}, 64'h1);
      checkOutput("rdata_hold", {32'h0, bus.RDATA}, {32'h0, exp[31:0]});
      checkOutput("arready_while_rvalid", {63'h0, bus.ARREADY}, 64'h0);
    end
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    checkOutput("rvalid_clear", {63'h0, bus.RVALID}, 64'h0);
    checkOutput("arready_after_r", {63'h0, bus.ARREADY}, 64'h1);
  endtask

  initial begin
    logic [31:0] addr, data;

    // T1: reset state
    doReset(3);
    checkOutput("rst_bvalid", {63'h0, bus.BVALID}, 64'h0);
    checkOutput("rst_rvalid", {63'h0, bus.RVALID}, 64'h0);
    checkOutput("rst_awready", {63'h0, bus.AWREADY}, 64'h1);
    checkOutput("rst_wready", {63'h0, bus.WREADY}, 64'h1);
    checkOutput("rst_arready", {63'h0, bus.ARREADY}, 64'h1);
    checkOutput("rst_bresp", {62'h0, bus.BRESP}, 64'h0);
    checkOutput("rst_rresp", {62'h0, bus.RRESP}, 64'h0);
    checkOutput("rst_rdata", {32'h0, bus.RDATA}, 64'h0);
    checkRegs();

    // T2: AW and W together, then read back
    applyWrite(32'h04, 32'hDEAD_BEEF, 0, 0, 0);
    checkOutput("reg1_flat", {32'h0, regs_o[63:32]}, 64'hDEAD_BEEF);
    applyRead(32'h04, 0);

    // T3: W first, AW three cycles later
    applyWrite(32'h08, 32'h11, 3, 0, 1);
    // AW first, W later
    applyWrite(32'h1C, 32'h7777_0007, 0, 2, 0);

    // T4: error responses and ignored byte offset
    applyWrite(32'h00, 32'h1234_5678, 0, 0, 0);
    applyRead(32'h00, 1);
    applyWrite(32'h20, 32'hCAFE_F00D, 1, 0, 0);
    applyRead(32'h20, 0);
    applyRead(32'hFFFF_FFFC, 0);
    applyWrite(32'h17, 32'h0BAD_CAFE, 0, 0, 0);
    applyRead(32'h15, 0);

    // T5: B backpressure while a second write is held
    bus.AWADDR = 32'h10; bus.WDATA = 32'h44;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    tick();
    m_regs[4] = 32'h44;
    checkOutput("bp_first_bvalid", {63'h0, bus.BVALID}, 64'h1);
    checkOutput("bp_first_bresp", {62'h0, bus.BRESP}, 64'h0);
    bus.AWADDR = 32'h18; bus.WDATA = 32'h66;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_bvalid_stable", {63'h0, bus.BVALID}, 64'h1);
      checkOutput("bp_bresp_stable", {62'h0, bus.BRESP}, 64'h0);
      checkOutput("bp_aw_held", {63'h0, bus.AWREADY}, 64'h0);
      checkOutput("bp_w_held", {63'h0, bus.WREADY}, 64'h0);
      checkOutput("bp_reg6_unchanged", {32'h0, regs_o[6*32 +: 32]}, {32'h0, m_regs[6]});
      tick();
    end
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    checkOutput("bp_b_accepted", {63'h0, bus.BVALID}, 64'h0);
    tick();
    m_regs[6] = 32'h66;
    checkOutput("bp_second_commit", {63'h0, bus.BVALID}, 64'h1);
    checkOutput("bp_second_bresp", {62'h0, bus.BRESP}, 64'h0);
    checkRegs();
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    checkOutput("bp_second_b_clear", {63'h0, bus.BVALID}, 64'h0);

    // T6: read colliding with a commit to the same register
    applyWrite(32'h0C, 32'h5, 0, 0, 0);
    bus.AWADDR = 32'h0C; bus.WDATA = 32'h9;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.ARADDR = 32'h0C; bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    checkOutput("col_bvalid", {63'h0, bus.BVALID}, 64'h1);
    checkOutput("col_rvalid", {63'h0, bus.RVALID}, 64'h1);
    checkOutput("col_rdata_old", {32'h0, bus.RDATA}, {32'h0, m_regs[3]});
    checkOutput("col_rresp", {62'h0, bus.RRESP}, 64'h0);
    m_regs[3] = 32'h9;
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    checkRegs();
    applyRead(32'h0C, 0);

    // T6: reset while a write address is held
    bus.AWADDR = 32'h14; bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    checkOutput("mid_aw_full", {63'h0, bus.AWREADY}, 64'h0);
    ARESETN = 1'b0;
    bus.WDATA = 32'h77; bus.WVALID = 1'b1;
    tick();
    ARESETN = 1'b1;
    bus.WVALID = 1'b0;
    model_reset();
    checkOutput("mid_awready", {63'h0, bus.AWREADY}, 64'h1);
    checkOutput("mid_wready", {63'h0, bus.WREADY}, 64'h1);
    tick();
    tick();
    checkOutput("mid_no_commit", {63'h0, bus.BVALID}, 64'h0);
    checkRegs();

    // Random transactions against the model
    for (int n = 0; n < 40; n++) begin
      addr = 32'($urandom_range(0, 4*NREG + 7));
      data = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        applyWrite(addr, data, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)));
      end else begin
        applyRead(addr, int'($urandom_range(0, 2)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
